// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder.
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int ADDR_W_DEF = 18;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  // Big-endian: byte offset 0 is the most significant lane.
  localparam logic [1:0] LANE_31_24 = 2'd0;
  localparam logic [1:0] LANE_23_16 = 2'd1;
  localparam logic [1:0] LANE_15_8  = 2'd2;
  localparam logic [1:0] LANE_7_0   = 2'd3;

  function automatic logic [3:0] lane_be(input logic [1:0] sel);
    lane_be = 4'b0000;
    unique case (sel)
      LANE_31_24: lane_be = 4'b1000;
      LANE_23_16: lane_be = 4'b0100;
      LANE_15_8:  lane_be = 4'b0010;
      LANE_7_0:   lane_be = 4'b0001;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Synchronous word store with per-byte write enables
// and a registered read port.
module data_mem_array #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             en,
  input  logic [3:0]       we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Latency-configurable data-memory responder (valid/ready).
// Define DATA_MEM_ALIGN_CHECK_EN to flag misaligned word accesses.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int ADDR_W      = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam bit DIRECT = (LATENCY == LAT_MIN);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              exec, mem_en;

  logic              l_write, l_byte;
  logic [ADDR_W-1:0] l_addr;
  logic [31:0]       l_wdata;

  logic              x_write, x_byte, x_misalign;
  logic [ADDR_W-1:0] x_addr, widx;
  logic [31:0]       x_wdata, wdata, rd;
  logic [3:0]        we;
  logic [IDX_W-1:0]  idx;

  logic              resp_load, err_q;
  logic [7:0]        sel_byte;
  logic [31:0]       ext;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    exec    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          cnt_d = CNT_LOAD;
          if (DIRECT) begin
            state_d = RESP;
            exec    = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_d = RESP;
          exec    = 1'b1;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      resp_load <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (exec) begin
        resp_load <= !x_write && !x_misalign;
        err_q     <= x_misalign;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (state == IDLE && req_valid) begin
      l_write <= req_write;
      l_byte  <= req_byte;
      l_addr  <= req_addr;
      l_wdata <= req_wdata;
    end
  end

  // With single-cycle latency the access runs off the live request.
  assign x_write = DIRECT ? req_write : l_write;
  assign x_byte  = DIRECT ? req_byte  : l_byte;
  assign x_addr  = DIRECT ? req_addr  : l_addr;
  assign x_wdata = DIRECT ? req_wdata : l_wdata;

`ifdef DATA_MEM_ALIGN_CHECK_EN
  assign x_misalign = !x_byte && (x_addr[1:0] != 2'b00);
`else
  assign x_misalign = 1'b0;
`endif

  assign widx   = {2'b00, x_addr[ADDR_W-1:2]};
  assign idx    = IDX_W'(widx % ADDR_W'(DEPTH_WORDS));
  assign mem_en = exec && !reset;
  assign wdata  = x_byte ? {4{x_wdata[7:0]}} : x_wdata;

  always_comb begin
    we = 4'b0000;
    if (x_write && !x_misalign) begin
      we = x_byte ? lane_be(x_addr[1:0]) : 4'b1111;
    end
  end

  data_mem_array #(
    .DEPTH (DEPTH_WORDS),
    .IDX_W (IDX_W)
  ) u_array (
    .clock (clock),
    .en    (mem_en),
    .we    (we),
    .idx   (idx),
    .wdata (wdata),
    .rdata (rd)
  );

  always_comb begin
    sel_byte = 8'h00;
    unique case (1'b1)
      l_addr[1:0] == LANE_31_24: sel_byte = rd[31:24];
      l_addr[1:0] == LANE_23_16: sel_byte = rd[23:16];
      l_addr[1:0] == LANE_15_8:  sel_byte = rd[15:8];
      l_addr[1:0] == LANE_7_0:   sel_byte = rd[7:0];
    endcase
    ext = l_byte ? {{24{sel_byte[7]}}, sel_byte} : rd;
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = resp_load ? ext : 32'h0;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: unit 0 runs LATENCY=2, unit 1 runs LATENCY=4.
module tb_data_mem_responder;

  logic        clock = 1'b0;
  logic        reset      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic        req_byte   [2];
  logic [17:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int total = 0;
  int bad   = 0;

  logic [31:0] rdat;
  logic        rerr;
  int          lat;

`ifdef DATA_MEM_ALIGN_CHECK_EN
  localparam logic [31:0] MIS_LD_DATA = 32'h0;
  localparam logic [31:0] MIS_ERR     = 32'h1;
  localparam logic [31:0] AFTER_MIS_ST = 32'h0A0B0C0D;
`else
  localparam logic [31:0] MIS_LD_DATA = 32'h0A0B0C0D;
  localparam logic [31:0] MIS_ERR     = 32'h0;
  localparam logic [31:0] AFTER_MIS_ST = 32'h00000099;
`endif

  always #5 clock = ~clock;

  data_mem_responder #(.LATENCY(2)) dut (
    .clock(clock), .reset(reset[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_byte(req_byte[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  data_mem_responder #(.LATENCY(4)) dut4 (
    .clock(clock), .reset(reset[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_byte(req_byte[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic access(input int u, input logic w, input logic b,
                        input logic [17:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er,
                        output int lt);
    int n;
    req_valid[u] = 1'b1;
    req_write[u] = w;
    req_byte[u]  = b;
    req_addr[u]  = a;
    req_wdata[u] = d;
    n = 0;
    while (!req_ready[u] && n < 20) begin
      tick();
      n++;
    end
    tick();
    req_valid[u] = 1'b0;
    lt = 0;
    while (!resp_valid[u] && lt < 40) begin
      tick();
      lt++;
    end
    chk("resp_arrived", 32'(resp_valid[u]), 32'h1);
    rd = resp_rdata[u];
    er = resp_err[u];
    resp_ready[u] = 1'b1;
    tick();
    resp_ready[u] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      reset[u] = 1'b1;
      req_valid[u] = 1'b0;
      req_write[u] = 1'b0;
      req_byte[u] = 1'b0;
      req_addr[u] = '0;
      req_wdata[u] = '0;
      resp_ready[u] = 1'b0;
    end
    repeat (2) tick();
    reset[0] = 1'b0;
    reset[1] = 1'b0;

    chk("rst_req_ready", 32'(req_ready[0]), 32'h1);
    chk("rst_resp_valid", 32'(resp_valid[0]), 32'h0);
    chk("rst_resp_rdata", resp_rdata[0], 32'h0);
    chk("rst_resp_err", 32'(resp_err[0]), 32'h0);
    chk("rst_req_ready4", 32'(req_ready[1]), 32'h1);

    access(0, 1, 0, 18'h10, 32'hDEADBEEF, rdat, rerr, lat);
    chk("sw_latency", 32'(lat), 32'd2);
    chk("sw_rdata", rdat, 32'h0);
    chk("sw_err", 32'(rerr), 32'h0);
    access(0, 0, 0, 18'h10, 32'h0, rdat, rerr, lat);
    chk("lw_rdata", rdat, 32'hDEADBEEF);
    chk("lw_latency", 32'(lat), 32'd2);

    access(0, 1, 0, 18'h20, 32'h11223344, rdat, rerr, lat);
    access(0, 1, 1, 18'h21, 32'h000000AA, rdat, rerr, lat);
    chk("sb_rdata", rdat, 32'h0);
    access(0, 0, 0, 18'h20, 32'h0, rdat, rerr, lat);
    chk("lw_after_sb", rdat, 32'h11AA3344);
    access(0, 0, 1, 18'h21, 32'h0, rdat, rerr, lat);
    chk("lb_21", rdat, 32'hFFFFFFAA);
    access(0, 0, 1, 18'h23, 32'h0, rdat, rerr, lat);
    chk("lb_23", rdat, 32'h00000044);
    access(0, 0, 1, 18'h20, 32'h0, rdat, rerr, lat);
    chk("lb_20", rdat, 32'h00000011);

    access(0, 1, 0, 18'h30, 32'h0, rdat, rerr, lat);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_byte[0]  = 1'b0;
    req_addr[0]  = 18'h20;
    tick();
    req_valid[0] = 1'b0;
    repeat (2) tick();
    chk("bp_arrive", 32'(resp_valid[0]), 32'h1);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 18'h30;
    req_wdata[0] = 32'hBADBAD00;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(resp_valid[0]), 32'h1);
      chk("bp_rdata", resp_rdata[0], 32'h11AA3344);
      chk("bp_req_ready", 32'(req_ready[0]), 32'h0);
    end
    req_valid[0] = 1'b0;
    resp_ready[0] = 1'b1;
    tick();
    resp_ready[0] = 1'b0;
    chk("bp_rel_valid", 32'(resp_valid[0]), 32'h0);
    chk("bp_rel_ready", 32'(req_ready[0]), 32'h1);
    access(0, 0, 0, 18'h30, 32'h0, rdat, rerr, lat);
    chk("bp_no_store", rdat, 32'h0);

    access(0, 1, 0, 18'h1004, 32'h5, rdat, rerr, lat);
    access(0, 0, 0, 18'h0004, 32'h0, rdat, rerr, lat);
    chk("wrap_load", rdat, 32'h5);

    access(1, 1, 0, 18'h40, 32'h777, rdat, rerr, lat);
    chk("lat4_latency", 32'(lat), 32'd4);
    req_valid[1] = 1'b1;
    req_write[1] = 1'b1;
    req_byte[1]  = 1'b0;
    req_addr[1]  = 18'h40;
    req_wdata[1] = 32'h1234;
    tick();
    req_valid[1] = 1'b0;
    chk("rw_accepted", 32'(req_ready[1]), 32'h0);
    tick();
    reset[1] = 1'b1;
    tick();
    reset[1] = 1'b0;
    chk("rw_valid", 32'(resp_valid[1]), 32'h0);
    chk("rw_ready", 32'(req_ready[1]), 32'h1);
    repeat (5) tick();
    chk("rw_no_late_resp", 32'(resp_valid[1]), 32'h0);
    access(1, 0, 0, 18'h40, 32'h0, rdat, rerr, lat);
    chk("rw_old_value", rdat, 32'h777);

    access(0, 1, 0, 18'h40, 32'h0A0B0C0D, rdat, rerr, lat);
    access(0, 0, 0, 18'h42, 32'h0, rdat, rerr, lat);
    chk("mis_lw_rdata", rdat, MIS_LD_DATA);
    chk("mis_lw_err", 32'(rerr), MIS_ERR);
    chk("mis_lw_latency", 32'(lat), 32'd2);
    access(0, 0, 1, 18'h42, 32'h0, rdat, rerr, lat);
    chk("mis_lb_rdata", rdat, 32'h0000000C);
    chk("mis_lb_err", 32'(rerr), 32'h0);
    access(0, 1, 0, 18'h42, 32'h99, rdat, rerr, lat);
    chk("mis_sw_err", 32'(rerr), MIS_ERR);
    chk("mis_sw_rdata", rdat, 32'h0);
    access(0, 0, 0, 18'h40, 32'h0, rdat, rerr, lat);
    chk("mis_sw_mem", rdat, AFTER_MIS_ST);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
